// File: rtl/feed_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : feed_frame_arbiter
// Description : Shares one frame unpacker between NUM_FEEDS byte feeds.
//               A frame is 0x7E, one type byte, then PAYLOAD_LEN payload
//               bytes. One feed is granted per frame, and grants rotate
//               round-robin at frame boundaries. While arbitrating, head
//               bytes that are not a delimiter are flushed. After every
//               frame, GAP_CYCLES idle cycles are forced on the output so
//               the unpacker never misses the next delimiter.
//
// Optional    : FEED_ARB_TIMEOUT_EN
//               When defined, a granted feed that stalls for TIMEOUT_CYCLES
//               consecutive cycles has its frame padded with 0x00 bytes.
//               frame_abort pulses on the last pad byte.
//               When undefined, a stalled grant waits forever and
//               frame_abort is tied low.
//
// Ports       : clk          clock
//               rst_n        asynchronous active-low reset
//               feed_data    head byte per feed, feed i at [i*8+7:i*8]
//               feed_valid   head byte valid per feed
//               feed_ready   pop strobe per feed (combinational)
//               out_data     byte to unpacker (registered)
//               out_valid    byte valid to unpacker (registered)
//               grant_id     feed currently or last granted
//               busy         high from delimiter accept until end of gap
//               frame_done   pulse with the last byte of a frame
//               frame_abort  pulse with the last pad byte of an aborted frame
//               drop_cnt     saturating count of flushed bytes
//
// Revision    : 1.0  initial release
// ============================================================================
module feed_frame_arbiter #(
  parameter int NUM_FEEDS      = 4,
  parameter int PAYLOAD_LEN    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_FEEDS*8-1:0]       feed_data,
  input  logic [NUM_FEEDS-1:0]         feed_valid,
  output logic [NUM_FEEDS-1:0]         feed_ready,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  output logic [$clog2(NUM_FEEDS)-1:0] grant_id,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_abort,
  output logic [15:0]                  drop_cnt
);

  localparam int         GW        = $clog2(NUM_FEEDS);
  localparam int         FRAME_LEN = PAYLOAD_LEN + 2;
  localparam int         CW        = $clog2(FRAME_LEN + 1);
  localparam int         GCW       = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0] DELIM     = 8'h7E;

  // Elaboration-time sanity check of the parameter ranges.
  generate
    if (NUM_FEEDS < 2 || NUM_FEEDS > 8 || PAYLOAD_LEN < 1 ||
        GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("feed_frame_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2,
    PAD   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t           state;
  logic [GW-1:0]    rr_ptr;
  logic [CW-1:0]    byte_cnt;
  logic [GCW-1:0]   gap_cnt;

  // Next-state values
  state_t           state_nxt;
  logic [GW-1:0]    rr_ptr_nxt;
  logic [GW-1:0]    grant_nxt;
  logic [CW-1:0]    byte_cnt_nxt;
  logic [GCW-1:0]   gap_cnt_nxt;
  logic             busy_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             done_nxt;
  logic [15:0]      drop_nxt;

  // --------------------------------------------------------------------------
  // Per-feed decode
  // --------------------------------------------------------------------------
  logic [7:0]           head [NUM_FEEDS];
  logic [NUM_FEEDS-1:0] cand;   // valid delimiter at head
  logic [NUM_FEEDS-1:0] junk;   // valid non-delimiter at head

  generate
    for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : g_feed
      assign head[gi] = feed_data[gi*8 +: 8];
      assign cand[gi] = feed_valid[gi] & (feed_data[gi*8 +: 8] == DELIM);
      assign junk[gi] = feed_valid[gi] & (feed_data[gi*8 +: 8] != DELIM);
    end
  endgenerate

  // Round-robin pick: first delimiter at or after rr_ptr, wrapping.
  logic          win_found;
  logic [GW-1:0] win_idx;
  int            scan_idx;
  logic [GW-1:0] scan_sel;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = 0; k < NUM_FEEDS; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_FEEDS) begin
        scan_idx = scan_idx - NUM_FEEDS;
      end
      scan_sel = GW'(scan_idx);
      if (!win_found && cand[scan_sel]) begin
        win_found = 1'b1;
        win_idx   = scan_sel;
      end
    end
  end

  // Number of junk bytes flushed this cycle (only meaningful in ARB).
  logic [3:0]  flush_n;
  logic [16:0] drop_sum;

  always_comb begin
    flush_n = '0;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      flush_n = flush_n + {3'b000, junk[i]};
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {13'd0, flush_n};

  // Shared helpers for the end of a frame.
  logic [CW-1:0] byte_cnt_inc;
  logic [GW-1:0] next_ptr;
  logic          last_byte;

  assign byte_cnt_inc = byte_cnt + CW'(1);
  assign last_byte    = (byte_cnt_inc == CW'(FRAME_LEN));
  assign next_ptr     = (grant_id == GW'(NUM_FEEDS - 1)) ? '0 : grant_id + GW'(1);

`ifdef FEED_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] stall_nxt;
  logic          abort_nxt;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_id;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    busy_nxt     = busy;
    data_nxt     = out_data;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    drop_nxt     = drop_cnt;
    feed_ready   = '0;
`ifdef FEED_ARB_TIMEOUT_EN
    stall_nxt    = stall_cnt;
    abort_nxt    = 1'b0;
`endif

    case (state)
      ARB: begin
        // Junk is popped from every feed regardless of who wins; losing
        // delimiters stay put for a later round.
        feed_ready = junk;
        drop_nxt   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (win_found) begin
          feed_ready[win_idx] = 1'b1;
          data_nxt            = DELIM;
          valid_nxt           = 1'b1;
          grant_nxt           = win_idx;
          busy_nxt            = 1'b1;
          byte_cnt_nxt        = CW'(1);
          state_nxt           = GRANT;
`ifdef FEED_ARB_TIMEOUT_EN
          stall_nxt           = '0;
`endif
        end
      end

      GRANT: begin
        feed_ready[grant_id] = 1'b1;
        if (feed_valid[grant_id]) begin
          // Content is not inspected: 0x7E mid-frame is payload.
          data_nxt     = head[grant_id];
          valid_nxt    = 1'b1;
          byte_cnt_nxt = byte_cnt_inc;
`ifdef FEED_ARB_TIMEOUT_EN
          stall_nxt    = '0;
`endif
          if (last_byte) begin
            done_nxt    = 1'b1;
            rr_ptr_nxt  = next_ptr;
            gap_cnt_nxt = '0;
            state_nxt   = GAP;
          end
        end
`ifdef FEED_ARB_TIMEOUT_EN
        else if (stall_cnt == SW'(TIMEOUT_CYCLES - 1)) begin
          stall_nxt = '0;
          state_nxt = PAD;
        end else begin
          stall_nxt = stall_cnt + SW'(1);
        end
`endif
      end

`ifdef FEED_ARB_TIMEOUT_EN
      PAD: begin
        // Complete the frame with zeros so the unpacker stays aligned.
        data_nxt     = 8'h00;
        valid_nxt    = 1'b1;
        byte_cnt_nxt = byte_cnt_inc;
        if (last_byte) begin
          abort_nxt   = 1'b1;
          rr_ptr_nxt  = next_ptr;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end
      end
`endif

      GAP: begin
        if (gap_cnt == GCW'(GAP_CYCLES - 1)) begin
          busy_nxt  = 1'b0;
          state_nxt = ARB;
        end else begin
          gap_cnt_nxt = gap_cnt + GCW'(1);
        end
      end

      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      grant_id   <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= 16'h0000;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_id   <= grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      busy       <= busy_nxt;
      out_data   <= data_nxt;
      out_valid  <= valid_nxt;
      frame_done <= done_nxt;
      drop_cnt   <= drop_nxt;
    end
  end

`ifdef FEED_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      frame_abort <= 1'b0;
    end else begin
      stall_cnt   <= stall_nxt;
      frame_abort <= abort_nxt;
    end
  end
`else
  assign frame_abort = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/feed_frame_arbiter.md
Name: feed_frame_arbiter

Overview:
- Shares one frame unpacker between NUM_FEEDS independent byte feeds (e.g. redundant exchange links).
- Grants the unpacker input to one feed per frame. A frame is the start delimiter 0x7E, then one type byte, then PAYLOAD_LEN payload bytes.
- Round-robin between feeds at frame boundaries. Non-frame bytes are flushed.
- Inserts the idle gap the unpacker needs after each frame so the next delimiter is never lost.

Parameters:
- NUM_FEEDS, 4, number of input feeds (2..8).
- PAYLOAD_LEN, 4, payload bytes per frame; must match the unpacker.
- GAP_CYCLES, 2, idle cycles forced on the output after the last byte of a frame (min 1).
- TIMEOUT_CYCLES, 16, stall limit used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- feed_data  in  NUM_FEEDS*8  head byte per feed; feed i is at [i*8+7:i*8]
- feed_valid  in  NUM_FEEDS  head byte valid per feed
- feed_ready  out  NUM_FEEDS  pop strobe per feed, combinational
- out_data  out  8  byte to unpacker rx_data, registered
- out_valid  out  1  to unpacker rx_data_valid, registered
- grant_id  out  clog2(NUM_FEEDS)  feed currently or last granted
- busy  out  1  high from delimiter accept until end of GAP
- frame_done  out  1  one-cycle pulse when the last frame byte is forwarded
- frame_abort  out  1  one-cycle pulse on a padded, aborted frame
- drop_cnt  out  16  count of flushed bytes, saturating

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values:
  - out_data=0x00, out_valid=0, grant_id=0, busy=0, frame_done=0, frame_abort=0, drop_cnt=0.
  - rr_ptr=0, state=ARB.
- Reset mid-frame abandons the frame with no flush or pad. The unpacker shares rst_n.
- Transfer rule: a byte moves when feed_valid[i] & feed_ready[i]. A transferred byte appears on out_data/out_valid the next cycle (latency 1). out_valid is 0 in every cycle with no transfer.
- ARB state:
  - Candidates are feeds with valid=1 and head==0x7E.
  - The winner is the first candidate at or after rr_ptr, modulo NUM_FEEDS.
  - The winner gets ready=1. Its delimiter is forwarded, grant_id<=winner, busy<=1, byte_cnt<=1, next state GRANT.
  - Feeds with valid=1 and head!=0x7E get ready=1 in the same cycle and are flushed. drop_cnt increments by the number flushed that cycle and saturates at 0xFFFF.
  - Losing candidates get ready=0 and keep their delimiter.
  - No candidates: stay in ARB; flushing still occurs.
- GRANT state:
  - feed_ready is 1 only for the granted feed. All other feeds are held with no flushing.
  - Each transfer forwards the byte and increments byte_cnt. Byte values are not checked, so 0x7E inside a frame is data.
  - When byte_cnt reaches PAYLOAD_LEN+2 (i.e. the transfer of byte PAYLOAD_LEN+2): frame_done pulses in the cycle out_valid carries that byte, rr_ptr<=(grant_id+1) mod NUM_FEEDS, next state GAP.
  - A granted feed with valid=0 simply stalls; out_valid=0 that cycle.
- GAP state:
  - All ready=0, out_valid=0 for GAP_CYCLES cycles.
  - Then busy<=0 and next state ARB.
  - The first new delimiter can reach out_valid no earlier than GAP_CYCLES+1 cycles after the last frame byte on out_valid.
- grant_id holds its value outside GRANT.
- frame_done and frame_abort are never both high.

Optional Feature:
- Macro FEED_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, TIMEOUT_CYCLES consecutive cycles with the granted feed_valid=0 trigger state PAD.
  - PAD drives ready=0 and emits out_valid=1, out_data=0x00 once per cycle until byte_cnt reaches PAYLOAD_LEN+2.
  - frame_abort pulses with the last pad byte and frame_done stays 0. Then GAP, with rr_ptr advanced as normal.
  - The stall counter clears on any granted transfer.
- Undefined: no timeout logic, GRANT waits indefinitely, frame_abort tied 0.

Test Plan:
- Feed0 sends 7E 01 AA BB CC DD, others idle:
  - out bytes match, 1 cycle late.
  - frame_done on the DD cycle.
  - 2 idle cycles, then busy=0; unpacker reports type=01, payload=AABBCCDD.
- Feeds 0 and 2 both present 7E at the same time, rr_ptr=0:
  - feed0's full frame first, then after GAP feed2's frame. No interleaving; grant_id 0 then 2.
- Feed1 presents 55 66 then 7E 02 11 22 33 44:
  - 55 and 66 are flushed, drop_cnt=2.
  - The frame is forwarded intact.
- Feed3 streams frames back-to-back with feed_valid always 1:
  - out_valid has exactly GAP_CYCLES zeros between frames and no delimiter is lost.
  - Unpacker msg_valid count equals frames sent.
- FEED_ARB_TIMEOUT_EN, feed0 sends 7E 01 AA then stalls 16 cycles:
  - pads 00 00 00; frame_abort pulses on the third pad byte.
  - rr_ptr=1.
- rst_n asserted after 3 bytes of a frame:
  - outputs go to reset values immediately.
  - A new frame from feed2 afterwards is forwarded correctly.
